// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the staggered multi-channel reset generator.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } seq_state_t;

  // Sequence count at which channel ch is released.
  function automatic int unsigned release_threshold(
    input int unsigned hold_cycles,
    input int unsigned stagger,
    input int unsigned ch
  );
    return hold_cycles + ch * stagger;
  endfunction

endpackage

// File: rtl/reset_pulse_channel.sv
// One reset output: held by the sequencer, released by strobe, re-pulsed on request.
module reset_pulse_channel #(
  parameter int unsigned PULSE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic assert_i,
  input  logic release_i,
  input  logic pulse_req_i,
  output logic ch_reset_o,
  output logic ch_reset_next_o
);

  localparam int unsigned PW = $clog2(PULSE_CYCLES + 1);
  localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CYCLES);

  logic          rst_d, rst_q;
  logic [PW-1:0] pcnt_d, pcnt_q;

  // The pulse counter only ever drops the output on its 1->0 step, so a
  // channel still held by the sequencer (counter idle at 0) stays asserted.
  always_comb begin
    rst_d  = rst_q;
    pcnt_d = pcnt_q;
    if (assert_i) begin
      rst_d  = 1'b1;
      pcnt_d = '0;
    end else if (release_i) begin
      rst_d = 1'b0;
    end else if (pulse_req_i) begin
      rst_d  = 1'b1;
      pcnt_d = PULSE_LOAD;
    end else if (pcnt_q != '0) begin
      pcnt_d = pcnt_q - PW'(1);
      if (pcnt_q == PW'(1)) rst_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q  <= 1'b1;
      pcnt_q <= '0;
    end else begin
      rst_q  <= rst_d;
      pcnt_q <= pcnt_d;
    end
  end

  assign ch_reset_o      = rst_q;
  assign ch_reset_next_o = rst_d;

endmodule

// File: rtl/reset_sequencer.sv
// Multi-channel reset generator: power-on hold, staggered release, restart and per-channel pulses.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned HOLD_CYCLES  = 100,
  parameter int unsigned STAGGER      = 16,
  parameter int unsigned PULSE_CYCLES = 8,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              CLK,
  input  logic              BReset,
  input  logic              Hold,
  input  logic              SwReq,
  input  logic [NUM_CH-1:0] ChSwReq,
  output logic [NUM_CH-1:0] ChReset,
  output logic              AllReleased,
  output logic              SeqBusy
);

  localparam int unsigned LAST_THR_I = release_threshold(HOLD_CYCLES, STAGGER, NUM_CH - 1);
  localparam logic [CNT_W-1:0] FIRST_THR = CNT_W'(release_threshold(HOLD_CYCLES, STAGGER, 0));
  localparam logic [CNT_W-1:0] LAST_THR  = CNT_W'(LAST_THR_I);

  if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
    $error("reset_sequencer: NUM_CH must be 1..32");
  end
  if (HOLD_CYCLES < 1 || PULSE_CYCLES < 1) begin : g_bad_cycles
    $error("reset_sequencer: HOLD_CYCLES and PULSE_CYCLES must be >= 1");
  end
  if (CNT_W < 1 || (CNT_W < 32 && longint'(LAST_THR_I) >= (longint'(1) << CNT_W))) begin : g_bad_cnt_w
    $error("reset_sequencer: CNT_W too small for last release threshold");
  end

  seq_state_t        state_d, state_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              all_rel_d, all_rel_q;
  logic              seq_active, sw_restart, pulse_en;
  logic [NUM_CH-1:0] ch_rst_next;

  // Release and state decisions look at the count being written this edge,
  // so a channel drops on the very edge its threshold is reached.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    seq_active = 1'b0;
    sw_restart = 1'b0;
    pulse_en   = 1'b0;
    unique case (state_q)
      ST_HOLD, ST_RELEASE: begin
        seq_active = 1'b1;
        if (!Hold && cnt_q != LAST_THR) cnt_d = cnt_q + CNT_W'(1);
        if (cnt_d == LAST_THR)       state_d = ST_RUN;
        else if (cnt_d >= FIRST_THR) state_d = ST_RELEASE;
      end
      ST_RUN: begin
        if (SwReq) begin
          sw_restart = 1'b1;
          cnt_d      = '0;
          state_d    = ST_HOLD;
        end else begin
          pulse_en = 1'b1;
        end
      end
      default: state_d = ST_HOLD;
    endcase
    all_rel_d = (state_d == ST_RUN) && !(|ch_rst_next);
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    localparam logic [CNT_W-1:0] THR = CNT_W'(release_threshold(HOLD_CYCLES, STAGGER, k));

    reset_pulse_channel #(
      .PULSE_CYCLES(PULSE_CYCLES)
    ) u_ch (
      .clk            (CLK),
      .rst            (BReset),
      .assert_i       (sw_restart),
      .release_i      (seq_active && (cnt_d == THR)),
      .pulse_req_i    (pulse_en && ChSwReq[k]),
      .ch_reset_o     (ChReset[k]),
      .ch_reset_next_o(ch_rst_next[k])
    );
  end

  always_ff @(posedge CLK) begin
    if (BReset) begin
      state_q   <= ST_HOLD;
      cnt_q     <= '0;
      all_rel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      all_rel_q <= all_rel_d;
    end
  end

  assign AllReleased = all_rel_q;
  assign SeqBusy     = (state_q != ST_RUN);

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: release tables plus hand-written pulse/restart sequences.
module tb_reset_sequencer;

  typedef struct {
    int         e;
    logic [3:0] ch;
    logic       ar;
    logic       busy;
  } vec_t;

  logic       clk = 1'b0;
  logic       b_reset, hold, sw_req;
  logic [3:0] ch_sw_req;
  logic [3:0] ch_reset;
  logic       all_rel, busy;

  logic b1_reset, sw1, chsw1;
  logic ch1_reset, all1, busy1;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;
  int hold_s = 1000, hold_e = 0;
  int noise_s = 1000, noise_e = 0;
  int noise1_s = 1000, noise1_e = 0;
  int plen, pviol;

  vec_t tbl1[8];
  vec_t tbl2[8];

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_CH(4), .HOLD_CYCLES(100), .STAGGER(16), .PULSE_CYCLES(8), .CNT_W(16)
  ) dut (
    .CLK(clk), .BReset(b_reset), .Hold(hold), .SwReq(sw_req), .ChSwReq(ch_sw_req),
    .ChReset(ch_reset), .AllReleased(all_rel), .SeqBusy(busy)
  );

  reset_sequencer #(
    .NUM_CH(1), .HOLD_CYCLES(100), .STAGGER(0), .PULSE_CYCLES(8), .CNT_W(8)
  ) dut1 (
    .CLK(clk), .BReset(b1_reset), .Hold(1'b0), .SwReq(sw1), .ChSwReq(chsw1),
    .ChReset(ch1_reset), .AllReleased(all1), .SeqBusy(busy1)
  );

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %h expected %h", nm, edge_n, act, exp);
    end
  endtask

  task automatic run_to(input int tgt);
    while (edge_n < tgt) begin
      hold      = (edge_n + 1 >= hold_s) && (edge_n + 1 <= hold_e);
      sw_req    = (edge_n + 1 >= noise_s) && (edge_n + 1 <= noise_e);
      ch_sw_req = sw_req ? 4'hF : 4'h0;
      sw1       = (edge_n + 1 >= noise1_s) && (edge_n + 1 <= noise1_e);
      chsw1     = sw1;
      step();
    end
    hold = 1'b0; sw_req = 1'b0; ch_sw_req = 4'h0; sw1 = 1'b0; chsw1 = 1'b0;
  endtask

  task automatic run_table(input string nm, input vec_t t[8]);
    for (int i = 0; i < 8; i++) begin
      run_to(t[i].e);
      chk({nm, "_ch"},   32'(ch_reset), 32'(t[i].ch));
      chk({nm, "_all"},  32'(all_rel),  32'(t[i].ar));
      chk({nm, "_busy"}, 32'(busy),     32'(t[i].busy));
    end
  endtask

  // Requests a pulse on channel 2 and counts the cycles it stays high;
  // re_at > 0 re-requests after that many observed high cycles.
  task automatic pulse_run(input int re_at, output int n, output int viol);
    n = 0;
    viol = 0;
    ch_sw_req = 4'b0100;
    step();
    ch_sw_req = 4'h0;
    while (ch_reset[2] === 1'b1 && n < 40) begin
      n++;
      if ((ch_reset & 4'b1011) != 4'h0 || all_rel !== 1'b0 || busy !== 1'b0) viol++;
      if (n == re_at) ch_sw_req = 4'b0100;
      step();
      ch_sw_req = 4'h0;
    end
  endtask

  initial begin
    tbl1[0] = '{98,  4'hF, 1'b0, 1'b1};
    tbl1[1] = '{99,  4'hE, 1'b0, 1'b1};
    tbl1[2] = '{114, 4'hE, 1'b0, 1'b1};
    tbl1[3] = '{115, 4'hC, 1'b0, 1'b1};
    tbl1[4] = '{130, 4'hC, 1'b0, 1'b1};
    tbl1[5] = '{131, 4'h8, 1'b0, 1'b1};
    tbl1[6] = '{146, 4'h8, 1'b0, 1'b1};
    tbl1[7] = '{147, 4'h0, 1'b1, 1'b0};

    tbl2[0] = '{108, 4'hF, 1'b0, 1'b1};
    tbl2[1] = '{109, 4'hE, 1'b0, 1'b1};
    tbl2[2] = '{124, 4'hE, 1'b0, 1'b1};
    tbl2[3] = '{125, 4'hC, 1'b0, 1'b1};
    tbl2[4] = '{140, 4'hC, 1'b0, 1'b1};
    tbl2[5] = '{141, 4'h8, 1'b0, 1'b1};
    tbl2[6] = '{156, 4'h8, 1'b0, 1'b1};
    tbl2[7] = '{157, 4'h0, 1'b1, 1'b0};

    b_reset = 1'b1; hold = 1'b0; sw_req = 1'b0; ch_sw_req = 4'h0;
    b1_reset = 1'b1; sw1 = 1'b0; chsw1 = 1'b0;

    // Power-on reset and first full sequence
    for (int i = 0; i < 5; i++) step();
    chk("reset_ch",   32'(ch_reset), 32'hF);
    chk("reset_all",  32'(all_rel),  32'h0);
    chk("reset_busy", 32'(busy),     32'h1);
    b_reset = 1'b0;
    edge_n = -1;
    run_table("seq", tbl1);

    // Single pulse on channel 2, then re-request at pulse cycle 5
    run_to(edge_n + 3);
    pulse_run(0, plen, pviol);
    chk("pulse_len",  32'(plen),    32'd8);
    chk("pulse_side", 32'(pviol),   32'd0);
    chk("pulse_end",  32'(all_rel), 32'h1);
    run_to(edge_n + 2);
    pulse_run(5, plen, pviol);
    chk("repulse_len",  32'(plen),     32'd13);
    chk("repulse_side", 32'(pviol),    32'd0);
    chk("repulse_ch",   32'(ch_reset), 32'h0);

    // SwReq together with ChSwReq[1]: full restart wins
    run_to(edge_n + 2);
    sw_req = 1'b1;
    ch_sw_req = 4'b0010;
    step();
    sw_req = 1'b0;
    ch_sw_req = 4'h0;
    chk("swreq_ch",   32'(ch_reset), 32'hF);
    chk("swreq_busy", 32'(busy),     32'h1);
    chk("swreq_all",  32'(all_rel),  32'h0);
    edge_n = -1;
    run_table("swseq", tbl1);

    // Restart again, then BReset mid-sequence after ch0 and ch1 released
    sw_req = 1'b1;
    step();
    sw_req = 1'b0;
    edge_n = -1;
    run_to(120);
    chk("mid_ch", 32'(ch_reset), 32'hC);
    b_reset = 1'b1;
    step();
    b_reset = 1'b0;
    chk("midrst_ch",   32'(ch_reset), 32'hF);
    chk("midrst_busy", 32'(busy),     32'h1);
    chk("midrst_all",  32'(all_rel),  32'h0);
    edge_n = -1;
    noise_s = 104; noise_e = 108;   // requests during RELEASE must be ignored
    run_table("rstseq", tbl1);
    noise_s = 1000; noise_e = 0;

    // Hold freezes the count for 10 cycles from edge 50
    b_reset = 1'b1;
    step();
    b_reset = 1'b0;
    edge_n = -1;
    hold_s = 50; hold_e = 59;
    run_table("hold", tbl2);
    hold_s = 1000; hold_e = 0;

    // Single-channel, zero-stagger build; requests during HOLD ignored
    b1_reset = 1'b0;
    edge_n = -1;
    chk("one_reset_ch",   32'(ch1_reset), 32'h1);
    chk("one_reset_busy", 32'(busy1),     32'h1);
    noise1_s = 10; noise1_e = 20;
    run_to(98);
    noise1_s = 1000; noise1_e = 0;
    chk("one_98_ch",   32'(ch1_reset), 32'h1);
    chk("one_98_busy", 32'(busy1),     32'h1);
    chk("one_98_all",  32'(all1),      32'h0);
    run_to(99);
    chk("one_99_ch",   32'(ch1_reset), 32'h0);
    chk("one_99_busy", 32'(busy1),     32'h0);
    chk("one_99_all",  32'(all1),      32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
